// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Imported by the top level and by the round-robin picker.
package mem_arb_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_e;

    // The counter is sized for the largest legal latency, so it fits any instance.
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

    localparam int PORT_CORE = 0;
    localparam int PORT_DBG  = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin winner selection.
// Purely combinational: a lone requester always wins, and a tie goes to the port not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_gnt : req[PORT_DBG];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the core load/store path (port 0) and a debug loader (port 1).
// Only one transaction is in flight at a time, and a read holds the memory until its data comes back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [ADDR_W-1:0]     i_addr0,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [DATA_W-1:0]     i_wdata0,
    input  logic [DATA_W-1:0]     i_wdata1,
    input  logic [DATA_W/8-1:0]   i_mask0,
    input  logic [DATA_W/8-1:0]   i_mask1,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_rvalid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_core_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_mask,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    arb_state_e         state;
    logic               last_gnt;
    logic               owner;
    logic [LAT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rdata_q;

    logic               pick_winner;
    logic               pick_valid;
    logic               grant_en;
    logic               win_we;
    logic               rd_done;

    rr_pick2 u_pick (
        .req      (i_req),
        .last_gnt (last_gnt),
        .winner   (pick_winner),
        .valid    (pick_valid)
    );

    // Grants are gated by reset so every output reads zero while reset is held.
    always_comb begin
        grant_en = i_reset & (state == IDLE) & pick_valid;
        win_we   = i_we[pick_winner];
        rd_done  = (state == RD_WAIT) && (cnt == '0);
    end

    // Grant strobe and field forwarding; read data is passed straight through on the completing cycle.
    always_comb begin
        o_gnt       = 2'b00;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        o_rvalid    = 2'b00;
        o_rdata     = rdata_q;
        if (grant_en) begin
            o_gnt[pick_winner] = 1'b1;
            o_mem_req          = 1'b1;
            o_mem_we           = win_we;
            if (pick_winner == 1'(PORT_DBG)) begin
                o_mem_addr  = i_addr1;
                o_mem_wdata = i_wdata1;
                o_mem_mask  = i_mask1;
            end else begin
                o_mem_addr  = i_addr0;
                o_mem_wdata = i_wdata0;
                o_mem_mask  = i_mask0;
            end
        end
        if (rd_done) begin
            o_rvalid[owner] = 1'b1;
            o_rdata         = i_mem_rdata;
        end
    end

    // The core stalls while it waits for a grant, while its read is in flight, and on its own read grant.
    always_comb begin
        o_core_stall = i_reset & (
                          (i_req[PORT_CORE] & ~o_gnt[PORT_CORE])
                        | ((state == RD_WAIT) & (owner == 1'(PORT_CORE)))
                        | (grant_en & (pick_winner == 1'(PORT_CORE)) & ~i_we[PORT_CORE]));
    end

    // Writes finish at grant. A read parks in RD_WAIT until the latency counter reaches zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
            cnt      <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        last_gnt <= pick_winner;
                        if (!win_we) begin
                            cnt   <= LAT_W'(MEM_LAT - 1);
                            owner <= pick_winner;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        rdata_q <= i_mem_rdata;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 main instance plus MEM_LAT=1 and MEM_LAT=4 instances for latency checks.
// Each instance is backed by a small pipelined memory model, and read data is scoreboarded per port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_v [3];
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  mask0, mask1;

    logic [1:0]  gnt_v       [3];
    logic [1:0]  rvalid_v    [3];
    logic [31:0] rdata_v     [3];
    logic        stall_v     [3];
    logic        mem_req_v   [3];
    logic        mem_we_v    [3];
    logic [31:0] mem_addr_v  [3];
    logic [31:0] mem_wdata_v [3];
    logic [3:0]  mem_mask_v  [3];
    logic [31:0] mem_rdata_v [3];

    int tests    = 0;
    int failures = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, 16'hC0DE};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int L = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        logic [31:0] pipe [4];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
            .i_clk        (clk),
            .i_reset      (rst_n),
            .i_req        (req_v[gi]),
            .i_we         (we),
            .i_addr0      (addr0),
            .i_addr1      (addr1),
            .i_wdata0     (wdata0),
            .i_wdata1     (wdata1),
            .i_mask0      (mask0),
            .i_mask1      (mask1),
            .o_gnt        (gnt_v[gi]),
            .o_rvalid     (rvalid_v[gi]),
            .o_rdata      (rdata_v[gi]),
            .o_core_stall (stall_v[gi]),
            .o_mem_req    (mem_req_v[gi]),
            .o_mem_we     (mem_we_v[gi]),
            .o_mem_addr   (mem_addr_v[gi]),
            .o_mem_wdata  (mem_wdata_v[gi]),
            .o_mem_mask   (mem_mask_v[gi]),
            .i_mem_rdata  (mem_rdata_v[gi])
        );

        // Read data appears L cycles after the strobe; any other slot carries garbage.
        always @(posedge clk) begin
            if (mem_req_v[gi] && !mem_we_v[gi]) pipe[0] <= mem_model(mem_addr_v[gi]);
            else                                pipe[0] <= 32'hBAD0_BAD0;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata_v[gi] = pipe[L-1];
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the main instance: every rvalid must match the oldest expected read of that port.
    always @(negedge clk) begin
        if (rst_n && rvalid_v[0] != 2'b00) begin
            if (rvalid_v[0] == 2'b01) begin
                if (exp_q0.size() > 0) check_output("rdata port0", rdata_v[0], exp_q0.pop_front());
                else                   check_output("rvalid port0 unexpected", rvalid_v[0], 2'b00);
            end else if (rvalid_v[0] == 2'b10) begin
                if (exp_q1.size() > 0) check_output("rdata port1", rdata_v[0], exp_q1.pop_front());
                else                   check_output("rvalid port1 unexpected", rvalid_v[0], 2'b00);
            end else begin
                check_output("rvalid onehot", rvalid_v[0], 2'b01);
            end
        end
    end

    task automatic sweep(input int idx, input int lat);
        int n;
        bit seen;
        next_cycle();
        req_v[idx] = 2'b01;
        we         = 2'b00;
        addr0      = 32'h0000_0600;
        @(negedge clk);
        check_output($sformatf("sweep lat%0d grant", lat), gnt_v[idx], 2'b01);
        next_cycle();
        req_v[idx] = 2'b00;
        n    = 1;
        seen = 0;
        while (!seen && n <= 10) begin
            @(negedge clk);
            if (rvalid_v[idx] != 2'b00) seen = 1;
            else n++;
        end
        check_output($sformatf("sweep lat%0d latency", lat), n, lat);
        check_output($sformatf("sweep lat%0d rvalid", lat), rvalid_v[idx], 2'b01);
        check_output($sformatf("sweep lat%0d rdata", lat), rdata_v[idx], mem_model(32'h0000_0600));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ngr;
        int iss [2];
        int p;
        bit got;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) req_v[i] = 2'b00;
        we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mask0 = '0; mask1 = '0;

        // Reset with both ports requesting: everything must stay quiet.
        req_v[0] = 2'b11;
        repeat (2) @(negedge clk);
        check_output("reset gnt", gnt_v[0], 2'b00);
        check_output("reset stall", stall_v[0], 1'b0);
        check_output("reset mem_req", mem_req_v[0], 1'b0);
        check_output("reset rvalid", rvalid_v[0], 2'b00);
        check_output("reset rdata", rdata_v[0], 32'h0);
        next_cycle();
        req_v[0] = 2'b00;
        rst_n    = 1'b1;

        // Single port-0 read at MEM_LAT=2.
        next_cycle();
        req_v[0] = 2'b01; addr0 = 32'h0000_0100;
        exp_q0.push_back(mem_model(32'h0000_0100));
        @(negedge clk);
        check_output("read t0 gnt", gnt_v[0], 2'b01);
        check_output("read t0 mem_req", mem_req_v[0], 1'b1);
        check_output("read t0 mem_addr", mem_addr_v[0], 32'h0000_0100);
        check_output("read t0 mem_we", mem_we_v[0], 1'b0);
        check_output("read t0 stall", stall_v[0], 1'b1);
        next_cycle();
        req_v[0] = 2'b00;
        @(negedge clk);
        check_output("read t1 gnt", gnt_v[0], 2'b00);
        check_output("read t1 mem_req", mem_req_v[0], 1'b0);
        check_output("read t1 stall", stall_v[0], 1'b1);
        check_output("read t1 rvalid", rvalid_v[0], 2'b00);
        next_cycle();
        @(negedge clk);
        check_output("read t2 rvalid", rvalid_v[0], 2'b01);
        check_output("read t2 rdata", rdata_v[0], 32'hDEAD_BEEF);
        check_output("read t2 stall", stall_v[0], 1'b1);
        next_cycle();
        @(negedge clk);
        check_output("read t3 rvalid", rvalid_v[0], 2'b00);
        check_output("read t3 stall", stall_v[0], 1'b0);
        check_output("read t3 rdata hold", rdata_v[0], 32'hDEAD_BEEF);

        // Back-to-back port-1 stores.
        next_cycle();
        req_v[0] = 2'b10; we = 2'b10; addr1 = 32'h0000_0200; wdata1 = 32'h11; mask1 = 4'hF;
        @(negedge clk);
        check_output("wr0 gnt", gnt_v[0], 2'b10);
        check_output("wr0 mem_we", mem_we_v[0], 1'b1);
        check_output("wr0 mem_addr", mem_addr_v[0], 32'h0000_0200);
        check_output("wr0 mem_wdata", mem_wdata_v[0], 32'h11);
        check_output("wr0 mem_mask", mem_mask_v[0], 4'hF);
        check_output("wr0 stall", stall_v[0], 1'b0);
        next_cycle();
        addr1 = 32'h0000_0204; wdata1 = 32'h22; mask1 = 4'h3;
        @(negedge clk);
        check_output("wr1 gnt", gnt_v[0], 2'b10);
        check_output("wr1 mem_addr", mem_addr_v[0], 32'h0000_0204);
        check_output("wr1 mem_wdata", mem_wdata_v[0], 32'h22);
        check_output("wr1 mem_mask", mem_mask_v[0], 4'h3);
        next_cycle();
        req_v[0] = 2'b00; we = 2'b00;
        @(negedge clk);
        check_output("wr idle mem_req", mem_req_v[0], 1'b0);
        check_output("wr idle rvalid", rvalid_v[0], 2'b00);

        // Port 1 requests during a port-0 read and withdraws before the read finishes.
        next_cycle();
        req_v[0] = 2'b01; addr0 = 32'h0000_0300;
        exp_q0.push_back(mem_model(32'h0000_0300));
        @(negedge clk);
        check_output("withdraw p0 gnt", gnt_v[0], 2'b01);
        next_cycle();
        req_v[0] = 2'b10; addr1 = 32'h0000_0400;
        @(negedge clk);
        check_output("withdraw wait gnt", gnt_v[0], 2'b00);
        next_cycle();
        req_v[0] = 2'b00;
        @(negedge clk);
        check_output("withdraw drop gnt", gnt_v[0], 2'b00);
        next_cycle();
        @(negedge clk);
        check_output("withdraw idle gnt", gnt_v[0], 2'b00);
        check_output("withdraw idle mem_req", mem_req_v[0], 1'b0);

        // Reset in the middle of a read: the in-flight response must be lost.
        next_cycle();
        req_v[0] = 2'b01; addr0 = 32'h0000_0500;
        exp_q0.push_back(mem_model(32'h0000_0500));
        @(negedge clk);
        check_output("midreset gnt", gnt_v[0], 2'b01);
        next_cycle();
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        req_v[0] = 2'b11;
        @(negedge clk);
        check_output("midreset gnt low", gnt_v[0], 2'b00);
        check_output("midreset rvalid", rvalid_v[0], 2'b00);
        check_output("midreset stall", stall_v[0], 1'b0);
        check_output("midreset mem_req", mem_req_v[0], 1'b0);
        check_output("midreset rdata", rdata_v[0], 32'h0);
        next_cycle();
        next_cycle();

        // Continuous contention straight out of reset: port 0 wins the first tie, then strict alternation.
        rst_n = 1'b1;
        addr0 = 32'h0000_1000; addr1 = 32'h0000_1100; we = 2'b00; req_v[0] = 2'b11;
        exp_q0.push_back(mem_model(32'h0000_1000));
        exp_q1.push_back(mem_model(32'h0000_1100));
        iss[0] = 1; iss[1] = 1; ngr = 0;
        for (int c = 0; c < 100 && ngr < 8; c++) begin
            @(negedge clk);
            got = 0;
            p   = 0;
            if (gnt_v[0] != 2'b00) begin
                check_output($sformatf("contention grant %0d", ngr), gnt_v[0], (ngr % 2 == 0) ? 2'b01 : 2'b10);
                ngr++;
                p   = gnt_v[0][1] ? 1 : 0;
                got = 1;
            end
            next_cycle();
            if (got) begin
                if (iss[p] < 4) begin
                    if (p == 0) begin
                        addr0 = 32'h0000_1000 + 32'(iss[0] * 4);
                        exp_q0.push_back(mem_model(addr0));
                    end else begin
                        addr1 = 32'h0000_1100 + 32'(iss[1] * 4);
                        exp_q1.push_back(mem_model(addr1));
                    end
                    iss[p]++;
                end else begin
                    req_v[0][p] = 1'b0;
                end
            end
        end
        check_output("contention grant count", ngr, 8);
        req_v[0] = 2'b00;
        for (int c = 0; c < 10 && (exp_q0.size() + exp_q1.size()) != 0; c++) @(negedge clk);
        check_output("scoreboard q0 drained", exp_q0.size(), 0);
        check_output("scoreboard q1 drained", exp_q1.size(), 0);

        // Latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances.
        sweep(1, 1);
        sweep(2, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
